// File: rtl/gpio_link_pkg.sv
// -----------------------------------------------------------------------------
// gpio_link_pkg
// Shared definitions for the inter-FPGA GPIO message link.
//   GPIO_WORD_W / GPIO_WORDS : default bus word width and words per message
//   rx_state_t               : receive FSM states (IDLE / RECV / ACK)
//   PIN_*                    : GPIO pin index map of the link connector
// -----------------------------------------------------------------------------
package gpio_link_pkg;

   localparam int unsigned GPIO_WORD_W = 32;
   localparam int unsigned GPIO_WORDS  = 4;

   // Pin map: DATA[31:0], forwarded clock, MESSAGE_DONE, and the two ready lines.
   localparam int unsigned PIN_DATA_LSB = 0;
   localparam int unsigned PIN_DATA_MSB = 31;
   localparam int unsigned PIN_CLK      = 32;
   localparam int unsigned PIN_DONE     = 33;
   localparam int unsigned PIN_RDY0     = 34;
   localparam int unsigned PIN_RDY1     = 35;

   typedef enum logic [1:0] {
      RX_IDLE = 2'd0,
      RX_RECV = 2'd1,
      RX_ACK  = 2'd2
   } rx_state_t;

endpackage

// File: rtl/gpio_message_receiver_if.sv
// -----------------------------------------------------------------------------
// gpio_message_receiver_if
// Bundles the receiver's link-side and consumer-side signals.
//   bus_data      : word driven by the peer on GPIO[31:0]
//   peer_valid    : peer ready/data-valid line
//   rx_ready      : receiver can accept a new message (this board's ready line)
//   ack           : MESSAGE_DONE pin
//   message_in    : last complete message, word k at [k*WORD_W +: WORD_W]
//   message_valid : message_in holds an untaken message
//   message_taken : consumer pulse clearing message_valid
//   err_abort     : one-cycle pulse, peer_valid dropped mid-message
//   err_timeout   : one-cycle pulse, peer never released after ack
// Modports: slave = the receiver, master = the peer/consumer side.
// -----------------------------------------------------------------------------
interface gpio_message_receiver_if
   import gpio_link_pkg::*;
#(
   parameter int unsigned WORD_W = GPIO_WORD_W,
   parameter int unsigned WORDS  = GPIO_WORDS
);

   logic [WORD_W-1:0]       bus_data;
   logic                    peer_valid;
   logic                    rx_ready;
   logic                    ack;
   logic [WORDS*WORD_W-1:0] message_in;
   logic                    message_valid;
   logic                    message_taken;
   logic                    err_abort;
   logic                    err_timeout;

   modport slave (
      input  bus_data, peer_valid, message_taken,
      output rx_ready, ack, message_in, message_valid, err_abort, err_timeout
   );

   modport master (
      output bus_data, peer_valid, message_taken,
      input  rx_ready, ack, message_in, message_valid, err_abort, err_timeout
   );

endinterface

// File: rtl/gpio_rx_assembler.sv
// -----------------------------------------------------------------------------
// gpio_rx_assembler
// Shadow word register file for an in-flight message.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_wr_en        : write i_wr_data into word i_wr_idx this edge
//   i_wr_idx       : word index being written
//   i_wr_data      : bus word
//   o_words        : parallel view of all words; the word being written this
//                    cycle is bypassed so the final word can be copied out
//                    on the same edge that writes it
// -----------------------------------------------------------------------------
module gpio_rx_assembler
   import gpio_link_pkg::*;
#(
   parameter  int unsigned WORD_W = GPIO_WORD_W,
   parameter  int unsigned WORDS  = GPIO_WORDS,
   localparam int unsigned IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_wr_en,
   input  logic [IDX_W-1:0]        i_wr_idx,
   input  logic [WORD_W-1:0]       i_wr_data,
   output logic [WORDS*WORD_W-1:0] o_words
);

   logic [WORD_W-1:0] r_words [WORDS];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned k = 0; k < WORDS; k++) begin
            r_words[k] <= '0;
         end
      end else if (i_wr_en) begin
         r_words[i_wr_idx] <= i_wr_data;
      end
   end

   always_comb begin
      o_words = '0;
      for (int unsigned k = 0; k < WORDS; k++) begin
         o_words[k*WORD_W +: WORD_W] =
            (i_wr_en && (32'(i_wr_idx) == k)) ? i_wr_data : r_words[k];
      end
   end

endmodule

// File: rtl/gpio_message_receiver.sv
// -----------------------------------------------------------------------------
// gpio_message_receiver
// Receive endpoint of the GPIO message link: samples WORDS bus words while
// peer_valid is high, publishes them atomically as message_in, raises ack
// (MESSAGE_DONE) until the peer drops peer_valid or ACK_TIMEOUT expires, and
// holds message_valid until the consumer pulses message_taken.
//   clock  : system clock, all logic on posedge
//   resetn : asynchronous active-low reset
//   bus    : gpio_message_receiver_if.slave (see interface header); its
//            WORD_W/WORDS must match this module's parameters
// Requires WORDS >= 2 and ACK_TIMEOUT >= 2.
// -----------------------------------------------------------------------------
module gpio_message_receiver
   import gpio_link_pkg::*;
#(
   parameter int unsigned WORD_W      = GPIO_WORD_W,
   parameter int unsigned WORDS       = GPIO_WORDS,
   parameter int unsigned ACK_TIMEOUT = 64
) (
   input  logic                  clock,
   input  logic                  resetn,
   gpio_message_receiver_if.slave bus
);

   localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int unsigned TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam int unsigned MSG_W = WORD_W * WORDS;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

   rx_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [TMO_W-1:0] r_tmo;
   logic             r_ack;
   logic             r_msg_valid;
   logic [MSG_W-1:0] r_msg;
   logic             r_err_abort;
   logic             r_err_timeout;

   logic             w_rx_ready;
   logic             w_start;
   logic             w_wr_en;
   logic [CNT_W-1:0] w_wr_idx;
   logic [MSG_W-1:0] w_words;

   assign w_rx_ready = (r_state == RX_IDLE) & ~r_msg_valid;
   assign w_start    = w_rx_ready & bus.peer_valid;
   assign w_wr_en    = w_start | ((r_state == RX_RECV) & bus.peer_valid);
   // Word 0 always lands at index 0; later words follow the running count.
   assign w_wr_idx   = (r_state == RX_RECV) ? r_cnt : '0;

   gpio_rx_assembler #(
      .WORD_W (WORD_W),
      .WORDS  (WORDS)
   ) u_assembler (
      .i_clk     (clock),
      .i_rst_n   (resetn),
      .i_wr_en   (w_wr_en),
      .i_wr_idx  (w_wr_idx),
      .i_wr_data (bus.bus_data),
      .o_words   (w_words)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state       <= RX_IDLE;
         r_cnt         <= '0;
         r_tmo         <= '0;
         r_ack         <= 1'b0;
         r_msg_valid   <= 1'b0;
         r_msg         <= '0;
         r_err_abort   <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         r_err_abort   <= 1'b0;
         r_err_timeout <= 1'b0;

         if (bus.message_taken && r_msg_valid) begin
            r_msg_valid <= 1'b0;
         end

         case (r_state)
            RX_IDLE: begin
               if (w_start) begin
                  r_cnt   <= CNT_W'(1);
                  r_state <= RX_RECV;
               end
            end
            RX_RECV: begin
               if (!bus.peer_valid) begin
                  r_err_abort <= 1'b1;
                  r_cnt       <= '0;
                  r_state     <= RX_IDLE;
               end else if (r_cnt == LAST_IDX) begin
                  // w_words already carries the final word via the bypass.
                  r_msg       <= w_words;
                  r_msg_valid <= 1'b1;
                  r_ack       <= 1'b1;
                  r_tmo       <= '0;
                  r_cnt       <= '0;
                  r_state     <= RX_ACK;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            RX_ACK: begin
               if (!bus.peer_valid) begin
                  r_ack   <= 1'b0;
                  r_tmo   <= '0;
                  r_state <= RX_IDLE;
               end else if (r_tmo == TMO_LAST) begin
                  r_err_timeout <= 1'b1;
                  r_ack         <= 1'b0;
                  r_tmo         <= '0;
                  r_state       <= RX_IDLE;
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
            end
            default: begin
               r_ack   <= 1'b0;
               r_cnt   <= '0;
               r_tmo   <= '0;
               r_state <= RX_IDLE;
            end
         endcase
      end
   end

   assign bus.rx_ready      = w_rx_ready;
   assign bus.ack           = r_ack;
   assign bus.message_in    = r_msg;
   assign bus.message_valid = r_msg_valid;
   assign bus.err_abort     = r_err_abort;
   assign bus.err_timeout   = r_err_timeout;

endmodule
